output_port_tx: RTL and testbench
=================================

OUTPUT_PORT_TX -- requirements
Module: output_port_tx

Interface
REQ-001 Parameter PACKET_BITS, 97, BFT packet width.
REQ-002 Parameter NUM_LEAF_BITS, 6, destination leaf field width.
REQ-003 Parameter NUM_PORT_BITS, 4, destination port field width.
REQ-004 Parameter NUM_ADDR_BITS, 7, receiver buffer word-address width; receiver capacity is 2**NUM_ADDR_BITS words.
REQ-005 Parameter PAYLOAD_BITS, 64, data word width.
REQ-006 Parameter FREESPACE_UPDATE_SIZE, 64, words returned per credit update.
REQ-007 clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 ap_start  in  1  run enable; low blocks new word launches.
REQ-010 dst_leaf  in  NUM_LEAF_BITS  destination leaf, sampled at launch.
REQ-011 dst_port  in  NUM_PORT_BITS  destination port, sampled at launch.
REQ-012 din_user2interface  in  PAYLOAD_BITS  user data word.
REQ-013 vld_user2interface  in  1  user word valid.
REQ-014 ack_interface2user  out  1  word accepted when vld and ack both high.
REQ-015 dout_interface2bft  out  PACKET_BITS  outgoing packet; MSB is valid bit.
REQ-016 ack_bft2interface  in  1  BFT accepted current packet this cycle.
REQ-017 freespace_update  in  1  one-cycle pulse: receiver freed FREESPACE_UPDATE_SIZE words.
REQ-018 credit_err  out  1  sticky; credit overflow detected.

Function
REQ-019 Packet format SHALL be {1'b1, dst_leaf, dst_port, zero fill, addr[NUM_ADDR_BITS-1:0], payload}; addr occupies bits [PAYLOAD_BITS+NUM_ADDR_BITS-1:PAYLOAD_BITS].
REQ-020 User words SHALL enter a 16-deep FIFO; ack_interface2user SHALL equal not-full.
REQ-021 Credit counter (NUM_ADDR_BITS+1 bits) SHALL reset to 2**NUM_ADDR_BITS.
REQ-022 FSM states: IDLE, RUN, WAIT_CREDIT.
REQ-023 IDLE->RUN when ap_start high; RUN->WAIT_CREDIT when credit is 0; WAIT_CREDIT->RUN when credit becomes nonzero; RUN or WAIT_CREDIT->IDLE when ap_start low and output register empty.
REQ-024 Launch SHALL occur in RUN when the FIFO is non-empty, credit>0, and the output register is empty or acked this cycle.
REQ-025 On launch, the packet SHALL appear on dout_interface2bft the next cycle, with FIFO read-to-packet latency of 1 cycle.
REQ-026 Packet SHALL hold stable until ack_bft2interface; valid bit clears the cycle after ack with no new launch.
REQ-027 Back-to-back launches with continuous ack SHALL give one packet per cycle.
REQ-028 addr SHALL start at 0, increment by 1 per launch, and wrap modulo 2**NUM_ADDR_BITS.
REQ-029 Credit SHALL decrement by 1 per launch and increment by FREESPACE_UPDATE_SIZE per update pulse; both in one cycle give net +FREESPACE_UPDATE_SIZE-1.
REQ-030 If an increment would exceed 2**NUM_ADDR_BITS, credit SHALL clamp at 2**NUM_ADDR_BITS and credit_err SHALL set until reset.
REQ-031 ap_start falling SHALL leave a held packet pending until acked; FIFO contents, addr and credit SHALL be retained.
REQ-032 FIFO SHALL stay writable in every state, including IDLE.

Reset
REQ-033 On rst_n low at clk edge: FSM=IDLE, FIFO empty, addr=0, credit=2**NUM_ADDR_BITS, dout_interface2bft=0, credit_err=0.
REQ-034 ack_interface2user SHALL be 1 the cycle after reset releases.
REQ-035 Reset mid-transfer SHALL discard the held packet and all FIFO words.

Structure
REQ-036 Packet field widths and offsets, plus FSM state encodings, SHALL live in the shared BFT package.
REQ-037 The user-side buffer SHALL be the existing SynFIFO (DSIZE=PAYLOAD_BITS, ASIZE=4) sub-module; the remaining logic stays flat.

Verification
REQ-038 Reset, ap_start=1, dst_leaf=5, dst_port=2, user sends 0xA5 with ack held high -> one packet, valid=1, leaf 5, port 2, addr 0, payload 0xA5, credit 127.
REQ-039 Send 128 words, no update -> 128 packets with addr 0..127, then WAIT_CREDIT with no packet; one update pulse -> 64 more launch, addr wraps to 0.
REQ-040 ack_bft2interface low for 5 cycles mid-stream -> packet stable for all 5 cycles, no words lost or duplicated, FIFO fills, and ack_interface2user drops at 16 words.
REQ-041 Update pulse coincident with a launch at credit 10 -> credit 73 next cycle.
REQ-042 Update pulse at full credit 128 -> credit stays 128, credit_err=1 until rst_n low.
REQ-043 rst_n low with 3 words in FIFO and a held packet -> next cycle valid=0, FIFO empty, addr=0, credit=128.

Source files
------------

// File: rtl/output_port_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_port_tx_pkg
// Description : Shared BFT definitions for the output port transmitter.
//               Default packet field widths, the helpers that place each
//               field inside a packet, and the transmitter FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package output_port_tx_pkg;

    // Default BFT geometry
    localparam int BFT_PACKET_BITS      = 97;
    localparam int BFT_NUM_LEAF_BITS    = 6;
    localparam int BFT_NUM_PORT_BITS    = 4;
    localparam int BFT_NUM_ADDR_BITS    = 7;
    localparam int BFT_PAYLOAD_BITS     = 64;
    localparam int BFT_FREESPACE_UPDATE = 64;

    // Packet layout, MSB first:
    //   {valid, leaf, port, zero fill, addr, payload}
    function automatic int pkt_valid_pos(input int packet_bits);
        return packet_bits - 1;
    endfunction

    function automatic int pkt_leaf_lsb(input int packet_bits, input int leaf_bits);
        return packet_bits - 1 - leaf_bits;
    endfunction

    function automatic int pkt_port_lsb(input int packet_bits, input int leaf_bits,
                                        input int port_bits);
        return packet_bits - 1 - leaf_bits - port_bits;
    endfunction

    function automatic int pkt_addr_lsb(input int payload_bits);
        return payload_bits;
    endfunction

    // Transmitter FSM
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_RUN         = 2'd1,
        ST_WAIT_CREDIT = 2'd2
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/SynFIFO.sv
`default_nettype none
// ============================================================================
// Module      : SynFIFO
// Description : Single-clock show-ahead FIFO, 2**ASIZE words of DSIZE bits.
//               rdata always presents the head word; rd_en pops it.
// Ports       : clk, rst_n (sync, active-low), wr_en/wdata (push),
//               rd_en/rdata (pop / head word), full, empty.
// Revision    : 1.0 - initial release
// ============================================================================
module SynFIFO #(
    parameter int DSIZE = 64,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rd_en,
    output logic [DSIZE-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2 ** ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                   (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);
    assign rdata = r_mem[r_rptr[ASIZE-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (ASIZE+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (ASIZE+1)'(1);
            end
        end
    end

    // Storage carries no reset so it can map onto RAM; emptiness is
    // tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[ASIZE-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_port_tx.sv
`default_nettype none
// ============================================================================
// Module      : output_port_tx
// Description : BFT output port transmitter. Buffers user words in a
//               16-deep FIFO, wraps each one into a BFT packet carrying the
//               destination leaf/port and a rolling receiver address, and
//               throttles launches with a credit counter refilled by
//               freespace_update pulses.
// Ports       : clk, rst_n (sync, active-low), ap_start (run enable),
//               dst_leaf/dst_port (destination), din/vld/ack user side,
//               dout_interface2bft/ack_bft2interface BFT side,
//               freespace_update (credit return), credit_err (sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module output_port_tx
    import output_port_tx_pkg::*;
#(
    parameter int PACKET_BITS           = BFT_PACKET_BITS,
    parameter int NUM_LEAF_BITS         = BFT_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS         = BFT_NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS         = BFT_NUM_ADDR_BITS,
    parameter int PAYLOAD_BITS          = BFT_PAYLOAD_BITS,
    parameter int FREESPACE_UPDATE_SIZE = BFT_FREESPACE_UPDATE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ap_start,
    input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] dst_port,
    input  logic [PAYLOAD_BITS-1:0]  din_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    output logic [PACKET_BITS-1:0]   dout_interface2bft,
    input  logic                     ack_bft2interface,
    input  logic                     freespace_update,
    output logic                     credit_err
);

    localparam int VALID_POS = pkt_valid_pos(PACKET_BITS);
    localparam int LEAF_LSB  = pkt_leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
    localparam int PORT_LSB  = pkt_port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
    localparam int ADDR_LSB  = pkt_addr_lsb(PAYLOAD_BITS);

    // Credit register is NUM_ADDR_BITS+1 wide; the next-value sum gets one
    // more bit so an over-range refill is visible before clamping.
    localparam int CW = NUM_ADDR_BITS + 1;
    localparam int SW = NUM_ADDR_BITS + 2;
    localparam logic [SW-1:0] C_CREDIT_MAX = SW'(2 ** NUM_ADDR_BITS);
    localparam logic [SW-1:0] C_UPDATE     = SW'(FREESPACE_UPDATE_SIZE);

    tx_state_t                r_state;
    logic [PACKET_BITS-1:0]   r_dout;
    logic [NUM_ADDR_BITS-1:0] r_addr;
    logic [CW-1:0]            r_credit;
    logic                     r_credit_err;

    logic [PAYLOAD_BITS-1:0]  w_fifo_rdata;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_out_valid;
    logic                     w_launch;
    logic [PACKET_BITS-1:0]   w_packet;
    logic [SW-1:0]            w_credit_sum;
    logic                     w_credit_ovf;

    // ------------------------------------------------------------------
    // User-side buffer: always writable, independent of the FSM state.
    // ------------------------------------------------------------------
    SynFIFO #(
        .DSIZE (PAYLOAD_BITS),
        .ASIZE (4)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (vld_user2interface),
        .wdata (din_user2interface),
        .rd_en (w_launch),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign ack_interface2user = !w_fifo_full;

    assign w_out_valid = r_dout[VALID_POS];

    // A new word may replace the held packet in the same cycle the BFT
    // accepts it, which is what sustains one packet per cycle.
    assign w_launch = (r_state == ST_RUN) && ap_start && !w_fifo_empty &&
                      (r_credit != '0) && (!w_out_valid || ack_bft2interface);

    always_comb begin
        w_packet                               = '0;
        w_packet[VALID_POS]                    = 1'b1;
        w_packet[LEAF_LSB +: NUM_LEAF_BITS]    = dst_leaf;
        w_packet[PORT_LSB +: NUM_PORT_BITS]    = dst_port;
        w_packet[ADDR_LSB +: NUM_ADDR_BITS]    = r_addr;
        w_packet[0 +: PAYLOAD_BITS]            = w_fifo_rdata;
    end

    // Launch and refill in the same cycle net out; a launch never happens
    // at zero credit, so the subtraction cannot underflow.
    assign w_credit_sum = SW'(r_credit)
                        + (freespace_update ? C_UPDATE : '0)
                        - SW'(w_launch);
    assign w_credit_ovf = freespace_update && (w_credit_sum > C_CREDIT_MAX);

    // ------------------------------------------------------------------
    // FSM with its registered datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dout       <= '0;
            r_addr       <= '0;
            r_credit     <= C_CREDIT_MAX[CW-1:0];
            r_credit_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A held packet keeps the FSM out of IDLE until the BFT
                    // takes it.
                    if (!ap_start && !w_out_valid) begin
                        r_state <= ST_IDLE;
                    end else if (r_credit == '0) begin
                        r_state <= ST_WAIT_CREDIT;
                    end
                end
                ST_WAIT_CREDIT: begin
                    if (!ap_start && !w_out_valid) begin
                        r_state <= ST_IDLE;
                    end else if (r_credit != '0) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_launch) begin
                r_dout <= w_packet;
                r_addr <= r_addr + NUM_ADDR_BITS'(1);
            end else if (w_out_valid && ack_bft2interface) begin
                r_dout <= '0;
            end

            r_credit <= w_credit_ovf ? C_CREDIT_MAX[CW-1:0] : w_credit_sum[CW-1:0];

            if (w_credit_ovf) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign dout_interface2bft = r_dout;
    assign credit_err         = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_output_port_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_port_tx
// Description : Self-checking bench for output_port_tx. A transaction-level
//               model tracks accepted user words (queue), the expected
//               receiver address and the credit balance, and checks every
//               packet the BFT side accepts plus the handshake outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_tx;

    localparam int PB   = 97;
    localparam int CMAX = 128;
    localparam int UPD  = 64;
    localparam int FDEP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic [5:0]  dst_leaf = '0;
    logic [3:0]  dst_port = '0;
    logic [63:0] din = '0;
    logic        vld = 1'b0;
    logic        ack_user;
    logic [PB-1:0] dout;
    logic        ack_bft = 1'b0;
    logic        upd = 1'b0;
    logic        credit_err;

    always #5 clk = ~clk;

    output_port_tx #(
        .PACKET_BITS           (97),
        .NUM_LEAF_BITS         (6),
        .NUM_PORT_BITS         (4),
        .NUM_ADDR_BITS         (7),
        .PAYLOAD_BITS          (64),
        .FREESPACE_UPDATE_SIZE (64)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ap_start           (ap_start),
        .dst_leaf           (dst_leaf),
        .dst_port           (dst_port),
        .din_user2interface (din),
        .vld_user2interface (vld),
        .ack_interface2user (ack_user),
        .dout_interface2bft (dout),
        .ack_bft2interface  (ack_bft),
        .freespace_update   (upd),
        .credit_err         (credit_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] exp_q[$];
    int  m_credit = CMAX;
    bit  m_err = 1'b0;
    int  m_addr = 0;
    int  launches = 0;
    int  last_addr = -1;
    bit  last_launch = 1'b0;

    // Stimulus knobs
    int          user_left = 0;
    int          vld_pct = 100;
    int          ack_pct = 100;
    bit          upd_req = 1'b0;
    bit          use_fixed = 1'b0;
    logic [63:0] fixed_din = '0;

    // One clock: drive inputs, predict the handshakes that the coming edge
    // completes, then update the model and check outputs 1 time unit later.
    task automatic step();
        logic [PB-1:0] pre_dout;
        logic [63:0]   word;
        logic [63:0]   head;
        bit pre_valid, w_acc, p_acc, now_valid, upd_now, rst_now;
        word    = use_fixed ? fixed_din : {$urandom, $urandom};
        vld     = (user_left > 0) && ($urandom_range(99) < vld_pct);
        din     = word;
        ack_bft = ($urandom_range(99) < ack_pct);
        upd     = upd_req;
        upd_now = upd_req;
        upd_req = 1'b0;
        rst_now = !rst_n;
        pre_dout  = dout;
        pre_valid = dout[PB-1];
        w_acc = vld && ack_user;
        p_acc = pre_valid && ack_bft;
        @(posedge clk);
        #1;
        now_valid   = dout[PB-1];
        last_launch = 1'b0;
        if (rst_now) begin
            exp_q.delete();
            m_credit = CMAX;
            m_err    = 1'b0;
            m_addr   = 0;
            return;
        end
        if (w_acc) begin
            exp_q.push_back(word);
            user_left--;
        end
        if (p_acc) begin
            check_val("pkt_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                head = exp_q.pop_front();
                check_val("pkt_payload", pre_dout[63:0], head);
                check_val("pkt_addr", pre_dout[70:64], m_addr);
                check_val("pkt_hdr", pre_dout[95:71], {dst_leaf, dst_port, 15'd0});
                last_addr = int'(pre_dout[70:64]);
                m_addr    = (m_addr + 1) % CMAX;
            end
        end
        if (pre_valid && !p_acc) begin
            check_val("hold_stable", dout, pre_dout);
        end
        if (now_valid && (!pre_valid || p_acc)) begin
            last_launch = 1'b1;
            launches++;
            check_val("launch_credit", m_credit > 0, 1);
            if (m_credit > 0) m_credit--;
        end
        if (upd_now) begin
            m_credit += UPD;
            if (m_credit > CMAX) begin
                m_credit = CMAX;
                m_err    = 1'b1;
            end
        end
        check_val("credit_err", credit_err, m_err);
        check_val("ack_user", ack_user, (exp_q.size() - int'(now_valid)) < FDEP);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        launches = 0;
    endtask

    initial begin
        logic [PB-1:0] exp_pkt;
        logic [PB-1:0] snap;
        int base;
        int rl;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check_val("rst_dout", dout, '0);
        check_val("rst_err", credit_err, 0);
        rst_n = 1'b1;
        launches = 0;
        step();
        check_val("rst_ack", ack_user, 1);

        // Single word 0xA5 to leaf 5 / port 2
        ap_start = 1'b1;
        dst_leaf = 6'd5;
        dst_port = 4'd2;
        ack_pct  = 100;
        vld_pct  = 100;
        run(3);
        use_fixed = 1'b1;
        fixed_din = 64'hA5;
        user_left = 1;
        step();
        use_fixed = 1'b0;
        check_val("a5_not_yet", dout[PB-1], 0);
        step();
        exp_pkt = {1'b1, 6'd5, 4'd2, 15'd0, 7'd0, 64'hA5};
        check_val("a5_packet", dout, exp_pkt);

        // Burst: only 128 launches fit the initial credit
        user_left = 200;
        run(400);
        check_val("burst_launches", launches, 128);
        check_val("burst_last_addr", last_addr, 127);
        check_val("burst_stalled", dout[PB-1], 0);
        check_val("burst_fifo_full", ack_user, 0);

        // One refill: 64 more launches, address wraps to 0..63
        upd_req = 1'b1;
        run(150);
        check_val("refill_launches", launches, 192);
        check_val("refill_wrap_addr", last_addr, 63);
        check_val("refill_stalled", dout[PB-1], 0);

        // Refill coincident with a launch at credit 10 -> 73 left
        user_left = 100000;
        upd_req = 1'b1;
        step();
        for (int i = 0; i < 300 && m_credit != 10; i++) step();
        upd_req = 1'b1;
        step();
        check_val("coinc_launch", last_launch, 1);
        base = launches;
        run(150);
        check_val("coinc_credit73", launches - base, 73);
        check_val("coinc_stalled", dout[PB-1], 0);

        // BFT stalls for 5 cycles mid-stream
        user_left = 30;
        upd_req = 1'b1;
        run(8);
        ack_pct = 0;
        step();
        snap = dout;
        run(4);
        check_val("stall_valid", dout[PB-1], 1);
        check_val("stall_held", dout, snap);
        check_val("stall_fifo_full", ack_user, 0);
        ack_pct = 100;
        run(150);
        check_val("stall_drained_valid", dout[PB-1], 0);
        check_val("stall_drained_ack", ack_user, 1);

        // FIFO fills while idle; then one packet per cycle
        do_reset();
        ap_start  = 1'b0;
        user_left = 20;
        run(25);
        check_val("prefill_words", 20 - user_left, FDEP);
        check_val("prefill_ack", ack_user, 0);
        check_val("prefill_no_pkt", dout[PB-1], 0);
        user_left = 0;
        ap_start  = 1'b1;
        for (int i = 0; i < 10 && !dout[PB-1]; i++) step();
        rl = 0;
        while (dout[PB-1] && rl < 40) begin
            rl++;
            step();
        end
        check_val("b2b_run_length", rl, FDEP);

        // Randomized traffic with ap_start toggling and random refills
        do_reset();
        dst_leaf  = 6'($urandom);
        dst_port  = 4'($urandom);
        user_left = 100000;
        for (int blk = 0; blk < 15; blk++) begin
            vld_pct = $urandom_range(100, 20);
            ack_pct = $urandom_range(100, 20);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(99) < 3) ap_start = !ap_start;
                if ($urandom_range(99) < 2) upd_req = 1'b1;
                step();
            end
        end
        user_left = 0;
        ap_start  = 1'b1;
        ack_pct   = 100;
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) begin
            if (m_credit == 0 && (i % 8) == 0) upd_req = 1'b1;
            step();
        end
        check_val("rand_drained", exp_q.size(), 0);
        run(5);
        check_val("rand_idle_valid", dout[PB-1], 0);

        // Reset with a held packet and 3 words queued
        do_reset();
        dst_leaf  = 6'd5;
        dst_port  = 4'd2;
        vld_pct   = 100;
        ap_start  = 1'b1;
        ack_pct   = 0;
        user_left = 4;
        run(10);
        check_val("mid_held", dout[PB-1], 1);
        check_val("mid_words_in", user_left, 0);
        rst_n = 1'b0;
        step();
        check_val("mid_rst_dout", dout, '0);
        rst_n = 1'b1;
        launches = 0;
        step();
        check_val("mid_rst_ack", ack_user, 1);
        ack_pct = 100;
        run(10);
        check_val("mid_no_stale", launches, 0);
        use_fixed = 1'b1;
        fixed_din = 64'h1234;
        user_left = 1;
        run(6);
        use_fixed = 1'b0;
        check_val("mid_addr_restart", last_addr, 0);

        // Refill at full credit saturates and flags an error until reset
        do_reset();
        ap_start = 1'b0;
        upd_req  = 1'b1;
        step();
        check_val("ovf_err_set", credit_err, 1);
        run(10);
        check_val("ovf_err_sticky", credit_err, 1);
        do_reset();
        check_val("ovf_err_cleared", credit_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
